// File: rtl/hack_pkg.sv
// Shared Hack ISA field layout, comp code table and encoder FSM states.
package hack_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned VALUE_W = 15;
  localparam int unsigned COMP_W  = 6;
  localparam int unsigned DEST_W  = 3;
  localparam int unsigned JUMP_W  = 3;

  localparam int unsigned OPC_BIT  = 15;
  localparam logic [2:0]  C_PREFIX = 3'b111;

  localparam int unsigned DEST_A_BIT = 5;
  localparam int unsigned DEST_D_BIT = 4;
  localparam int unsigned DEST_M_BIT = 3;
  localparam int unsigned JUMP_J1_BIT = 2;
  localparam int unsigned JUMP_J2_BIT = 1;
  localparam int unsigned JUMP_J3_BIT = 0;

  // comp codes c1..c6; names use A, the a=1 variants substitute M
  localparam logic [5:0] COMP_ZERO      = 6'b101010;
  localparam logic [5:0] COMP_ONE       = 6'b111111;
  localparam logic [5:0] COMP_NEG_ONE   = 6'b111010;
  localparam logic [5:0] COMP_D         = 6'b001100;
  localparam logic [5:0] COMP_A         = 6'b110000;
  localparam logic [5:0] COMP_NOT_D     = 6'b001101;
  localparam logic [5:0] COMP_NOT_A     = 6'b110001;
  localparam logic [5:0] COMP_NEG_D     = 6'b001111;
  localparam logic [5:0] COMP_NEG_A     = 6'b110011;
  localparam logic [5:0] COMP_D_PLUS_1  = 6'b011111;
  localparam logic [5:0] COMP_A_PLUS_1  = 6'b110111;
  localparam logic [5:0] COMP_D_MINUS_1 = 6'b001110;
  localparam logic [5:0] COMP_A_MINUS_1 = 6'b110010;
  localparam logic [5:0] COMP_D_PLUS_A  = 6'b000010;
  localparam logic [5:0] COMP_D_MINUS_A = 6'b010011;
  localparam logic [5:0] COMP_A_MINUS_D = 6'b000111;
  localparam logic [5:0] COMP_D_AND_A   = 6'b000000;
  localparam logic [5:0] COMP_D_OR_A    = 6'b010101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_OVF  = 2'd3
  } enc_state_t;

  function automatic logic [WORD_W-1:0] encode_word(
    input logic               is_c,
    input logic [VALUE_W-1:0] value,
    input logic               a,
    input logic [COMP_W-1:0]  comp,
    input logic [DEST_W-1:0]  dest,
    input logic [JUMP_W-1:0]  jump
  );
    if (is_c) return {C_PREFIX, a, comp, dest, jump};
    return {1'b0, value};
  endfunction

endpackage

// File: rtl/hack_comp_check.sv
// Combinational legality check of a C-instruction comp field against the Hack ALU table.
module hack_comp_check
  import hack_pkg::*;
(
  input  logic              i_a,
  input  logic [COMP_W-1:0] i_comp,
  output logic              o_legal_c
);

  logic w_uses_a;
  logic w_const_or_d;

  // codes that read the A/M operand are legal with either a-bit value
  always_comb begin
    w_uses_a = 1'b0;
    case (i_comp)
      COMP_A, COMP_NOT_A, COMP_NEG_A, COMP_A_PLUS_1, COMP_A_MINUS_1,
      COMP_D_PLUS_A, COMP_D_MINUS_A, COMP_A_MINUS_D, COMP_D_AND_A,
      COMP_D_OR_A: w_uses_a = 1'b1;
      default:     w_uses_a = 1'b0;
    endcase
  end

  always_comb begin
    w_const_or_d = 1'b0;
    case (i_comp)
      COMP_ZERO, COMP_ONE, COMP_NEG_ONE, COMP_D, COMP_NOT_D, COMP_NEG_D,
      COMP_D_PLUS_1, COMP_D_MINUS_1: w_const_or_d = 1'b1;
      default:                       w_const_or_d = 1'b0;
    endcase
  end

  assign o_legal_c = w_uses_a | (~i_a & w_const_or_d);

endmodule

// File: rtl/hack_encoder.sv
// Packs symbolic Hack instruction bundles into 16-bit words and streams them into the ROM.
// Optional comp legality filtering is enabled by defining HACK_ENC_COMP_CHECK_EN.
module hack_encoder
  import hack_pkg::*;
#(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DEPTH  = 32768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_c,
  input  logic [14:0]       in_value,
  input  logic              in_a,
  input  logic [5:0]        in_comp,
  input  logic [2:0]        in_dest,
  input  logic [2:0]        in_jump,
  input  logic              in_last,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
`ifdef HACK_ENC_COMP_CHECK_EN
  output logic [ADDR_W:0]   count,
  output logic              illegal
`else
  output logic [ADDR_W:0]   count
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  enc_state_t        r_state;
  enc_state_t        w_state_nx;
  logic              r_pend;
  logic              r_last;
  logic [15:0]       r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic              r_done;
  logic              r_overflow;

  logic              w_run;
  logic [ADDR_W:0]   w_cnt_inc;
  logic              w_full;
  logic              w_xfer;
  logic              w_legal;
  logic              w_accept;
  logic              w_drop_last;

  assign w_run     = (r_state == ST_RUN);
  assign w_cnt_inc = r_count + (ADDR_W+1)'(1);
  assign w_full    = r_pend & (w_cnt_inc == DEPTH_C);

  // a pending word can be replaced in the same cycle unless it closes the session
  assign in_ready = w_run & (~r_pend | (~r_last & ~w_full));
  assign w_xfer   = in_valid & in_ready;

`ifdef HACK_ENC_COMP_CHECK_EN
  logic w_comp_ok;
  logic r_illegal;

  hack_comp_check u_comp_check (
    .i_a       (in_a),
    .i_comp    (in_comp),
    .o_legal_c (w_comp_ok)
  );

  assign w_legal = ~in_is_c | w_comp_ok;
  assign illegal = r_illegal;
`else
  assign w_legal = 1'b1;
`endif

  assign w_accept    = w_xfer & w_legal;
  assign w_drop_last = w_xfer & ~w_legal & in_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_RUN: begin
        if (r_pend && r_last) w_state_nx = ST_DONE;
        else if (w_full)      w_state_nx = ST_OVF;
        else if (w_drop_last) w_state_nx = ST_DONE;
      end
      default: if (start) w_state_nx = ST_RUN;
    endcase
  end

  // session datapath: word register, address and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= 1'b0;
      r_last     <= 1'b0;
      r_wdata    <= '0;
      r_addr     <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (!w_run) begin
      if (start) begin
        r_pend     <= 1'b0;
        r_last     <= 1'b0;
        r_addr     <= '0;
        r_count    <= '0;
        r_done     <= 1'b0;
        r_overflow <= 1'b0;
      end
    end else begin
      if (r_pend) begin
        r_count <= w_cnt_inc;
        if (w_cnt_inc < DEPTH_C) r_addr <= r_addr + ADDR_W'(1);
        if (r_last)      r_done     <= 1'b1;
        else if (w_full) r_overflow <= 1'b1;
      end
      if (w_drop_last) r_done <= 1'b1;
      r_pend <= w_accept;
      if (w_accept) begin
        r_wdata <= encode_word(in_is_c, in_value, in_a, in_comp, in_dest, in_jump);
        r_last  <= in_last;
      end
    end
  end

`ifdef HACK_ENC_COMP_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_illegal <= 1'b0;
    else if (!w_run && start)         r_illegal <= 1'b0;
    else if (w_xfer && !w_legal)      r_illegal <= 1'b1;
  end
`endif

  assign rom_we    = r_pend;
  assign rom_addr  = r_addr;
  assign rom_wdata = r_wdata;
  assign busy      = w_run | r_pend;
  assign done      = r_done;
  assign overflow  = r_overflow;
  assign count     = r_count;

endmodule

// File: tb/tb_hack_encoder.sv
// Directed self-checking bench for hack_encoder (DEPTH=4 so overflow is reachable quickly).
module tb_hack_encoder;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_is_c = 1'b0;
  logic [14:0]       in_value = '0;
  logic              in_a = 1'b0;
  logic [5:0]        in_comp = '0;
  logic [2:0]        in_dest = '0;
  logic [2:0]        in_jump = '0;
  logic              in_last = 1'b0;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_wdata;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   count;
`ifdef HACK_ENC_COMP_CHECK_EN
  logic              illegal;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int q_addr[$];
  int q_data[$];
  int q_cyc[$];
  bit ok;

  hack_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_is_c   (in_is_c),
    .in_value  (in_value),
    .in_a      (in_a),
    .in_comp   (in_comp),
    .in_dest   (in_dest),
    .in_jump   (in_jump),
    .in_last   (in_last),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
`ifdef HACK_ENC_COMP_CHECK_EN
    .count     (count),
    .illegal   (illegal)
`else
    .count     (count)
`endif
  );

  always #5 clk = ~clk;

  // ROM write log: one entry per cycle with rom_we high
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rom_we) begin
      q_addr.push_back(int'(rom_addr));
      q_data.push_back(int'(rom_wdata));
      q_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // present a bundle; accepted=0 if it never transfers within the budget
  task automatic send(input logic is_c, input logic [14:0] value, input logic a,
                      input logic [5:0] comp, input logic [2:0] dest, input logic [2:0] jump,
                      input logic last, output bit accepted);
    bit rdy;
    in_is_c = is_c; in_value = value; in_a = a; in_comp = comp;
    in_dest = dest; in_jump = jump; in_last = last; in_valid = 1'b1;
    accepted = 1'b0;
    for (int n = 0; n < 20 && !accepted; n++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      accepted = rdy;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_a(input logic [14:0] value, input logic last);
    bit acc;
    send(1'b0, value, 1'b0, 6'd0, 3'd0, 3'd0, last, acc);
    check("send_a accepted", 32'(acc), 32'd1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input int idx, input int addr, input int data);
    if (q_addr.size() > idx) begin
      check({tag, " addr"}, 32'(q_addr[idx]), 32'(addr));
      check({tag, " data"}, 32'(q_data[idx]), 32'(data));
    end else begin
      check({tag, " present"}, 32'(q_addr.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    // reset state
    #2;
    check("rst rom_we", 32'(rom_we), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst count", 32'(count), 32'd0);
    check("rst rom_addr", 32'(rom_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // bundle held while IDLE is not accepted
    clear_log();
    in_is_c = 1'b0; in_value = 15'h0015; in_valid = 1'b1;
    @(negedge clk);
    check("idle in_ready", 32'(in_ready), 32'd0);
    settle(3);
    check("idle no write", 32'(q_addr.size()), 32'd0);

    // A/C encode session, held bundle writes after start
    pulse_start();
    check("start busy", 32'(busy), 32'd1);
    send_a(15'h0015, 1'b0);
    send(1'b1, 15'd0, 1'b1, 6'b110111, 3'b010, 3'b000, 1'b0, ok);
    check("c1 accepted", 32'(ok), 32'd1);
    send(1'b1, 15'd0, 1'b0, 6'b101010, 3'b000, 3'b111, 1'b1, ok);
    check("c2 accepted", 32'(ok), 32'd1);
    settle(3);
    check("enc nwrites", 32'(q_addr.size()), 32'd3);
    check_write("enc w0", 0, 0, 16'h0015);
    check_write("enc w1", 1, 1, 16'hFDD0);
    check_write("enc w2", 2, 2, 16'hEA87);
    if (q_cyc.size() == 3) begin
      check("enc b2b 1", 32'(q_cyc[1] - q_cyc[0]), 32'd1);
      check("enc b2b 2", 32'(q_cyc[2] - q_cyc[1]), 32'd1);
    end
    check("enc done", 32'(done), 32'd1);
    check("enc count", 32'(count), 32'd3);
    check("enc busy", 32'(busy), 32'd0);
    check("enc in_ready", 32'(in_ready), 32'd0);

    // restart after DONE
    clear_log();
    pulse_start();
    check("restart done clr", 32'(done), 32'd0);
    check("restart count", 32'(count), 32'd0);
    check("restart addr", 32'(rom_addr), 32'd0);
    send_a(15'h1234, 1'b0);
    send_a(15'h7FFF, 1'b1);
    settle(3);
    check("restart nwrites", 32'(q_addr.size()), 32'd2);
    check_write("restart w0", 0, 0, 16'h1234);
    check_write("restart w1", 1, 1, 16'h7FFF);
    check("restart done", 32'(done), 32'd1);
    check("restart count2", 32'(count), 32'd2);

    // overflow: DEPTH words without last, the next one never transfers
    clear_log();
    pulse_start();
    for (int i = 0; i < 4; i++) send_a(15'(16'h0100 + i), 1'b0);
    send(1'b0, 15'h0555, 1'b0, 6'd0, 3'd0, 3'd0, 1'b0, ok);
    check("ovf 5th rejected", 32'(ok), 32'd0);
    check("ovf nwrites", 32'(q_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_write("ovf w", i, i, 16'h0100 + i);
    check("ovf flag", 32'(overflow), 32'd1);
    check("ovf done", 32'(done), 32'd0);
    check("ovf count", 32'(count), 32'd4);
    check("ovf addr cap", 32'(rom_addr), 32'd3);
    check("ovf in_ready", 32'(in_ready), 32'd0);
    check("ovf state", 32'(dut.r_state), 32'd3);

    // last on word DEPTH ends in DONE, not OVF
    clear_log();
    pulse_start();
    check("edge ovf clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) send_a(15'(16'h0200 + i), (i == 3) ? 1'b1 : 1'b0);
    settle(2);
    check("edge nwrites", 32'(q_addr.size()), 32'd4);
    check("edge done", 32'(done), 32'd1);
    check("edge overflow", 32'(overflow), 32'd0);
    check("edge count", 32'(count), 32'd4);
    check("edge addr cap", 32'(rom_addr), 32'd3);

    // reset mid-session with a pending word
    clear_log();
    pulse_start();
    send_a(15'h0011, 1'b0);
    send_a(15'h0022, 1'b0);
    check("mid pending we", 32'(rom_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid rst we", 32'(rom_we), 32'd0);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst count", 32'(count), 32'd0);
    check("mid rst addr", 32'(rom_addr), 32'd0);
    settle(1);
    rst = 1'b0;
    check("mid nwrites", 32'(q_addr.size()), 32'd1);
    clear_log();
    pulse_start();
    send_a(15'h0042, 1'b1);
    settle(2);
    check_write("mid new w0", 0, 0, 16'h0042);
    check("mid new count", 32'(count), 32'd1);

`ifdef HACK_ENC_COMP_CHECK_EN
    // illegal comp accepted but dropped; next word reuses the address
    clear_log();
    pulse_start();
    check("ill clr", 32'(illegal), 32'd0);
    send(1'b1, 15'd0, 1'b1, 6'b001100, 3'b001, 3'b000, 1'b0, ok);
    check("ill accepted", 32'(ok), 32'd1);
    settle(1);
    check("ill no write", 32'(q_addr.size()), 32'd0);
    check("ill flag", 32'(illegal), 32'd1);
    check("ill count", 32'(count), 32'd0);
    send_a(15'h0007, 1'b1);
    settle(2);
    check_write("ill next", 0, 0, 16'h0007);
    check("ill count2", 32'(count), 32'd1);
    // illegal bundle carrying last still closes the session
    pulse_start();
    send(1'b1, 15'd0, 1'b0, 6'b111110, 3'b000, 3'b000, 1'b1, ok);
    settle(2);
    check("ill last done", 32'(done), 32'd1);
    check("ill last count", 32'(count), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
